// File: rtl/knn_best_mem_ctrl_pkg.sv
// Shared types and sizes for the kNN best-result store.
// Holds the leaf/query geometry, the packed row layout and small helpers
// used by the controller, its row RAM and the bus interface.
package knn_best_pkg;

  localparam int LEAF_SIZE  = 8;
  localparam int NUM_LEAVES = 64;
  localparam int ROW_SIZE   = 24;
  localparam int COL_SIZE   = 17;
  localparam int K          = 4;

  localparam int IDX_W      = $clog2(NUM_LEAVES) + $clog2(LEAF_SIZE);
  localparam int ROW_W      = K * IDX_W;
  localparam int NUM_QUERYS = ROW_SIZE * COL_SIZE;
  localparam int QADDR_W    = $clog2(NUM_QUERYS);
  localparam int BEAT_W     = $clog2(K);
  localparam int SHIFT_W    = (K - 1) * IDX_W;
  localparam int RDATA_W    = 64;

  typedef logic [ROW_W-1:0]   best_row_t;
  typedef logic [IDX_W-1:0]   best_idx_t;
  typedef logic [QADDR_W-1:0] qaddr_t;
  typedef logic [BEAT_W-1:0]  beat_t;

  // True when a row address points inside the populated part of the store.
  function automatic logic addr_in_range(input qaddr_t addr);
    return (addr < QADDR_W'(NUM_QUERYS));
  endfunction

endpackage

// File: rtl/knn_best_mem_ctrl_if.sv
// Bus bundle of the best-result store: the engine's result stream
// (valid/ready/index) and the Wishbone block's SRAM-style read port.
// master = engine + Wishbone side, slave = the store.
interface knn_best_mem_ctrl_if;
  import knn_best_pkg::*;

  logic                 res_valid;
  logic                 res_ready;
  best_idx_t            res_idx;
  logic                 wbs_best_mem_csb0;
  logic                 wbs_best_mem_web0;
  qaddr_t               wbs_best_mem_addr0;
  logic [RDATA_W-1:0]   wbs_best_mem_rdata0;

  modport master (
    output res_valid, res_idx,
    output wbs_best_mem_csb0, wbs_best_mem_web0, wbs_best_mem_addr0,
    input  res_ready, wbs_best_mem_rdata0
  );

  modport slave (
    input  res_valid, res_idx,
    input  wbs_best_mem_csb0, wbs_best_mem_web0, wbs_best_mem_addr0,
    output res_ready, wbs_best_mem_rdata0
  );

endinterface

// File: rtl/knn_best_mem_ctrl_best_row_ram.sv
// Behavioural single-port row store, NUM_QUERYS rows of ROW_W bits.
// Registered read; during a write the output register takes the new
// data (write-first). Contents are never cleared.
module best_row_ram
  import knn_best_pkg::*;
(
  input  logic      clk,
  input  logic      en,
  input  logic      we,
  input  qaddr_t    addr,
  input  best_row_t wdata,
  output best_row_t rdata
);

  best_row_t mem [NUM_QUERYS];
  best_row_t rdata_q;

  // Array write and registered, write-first read port.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata_q   <= wdata;
      end else begin
        rdata_q   <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/knn_best_mem_ctrl.sv
// kNN best-result store controller.
// Collects K best leaf indices per query from the search engine, packs
// them into one row and writes rows in query order; in debug mode the
// Wishbone block reads rows back over an SRAM-style port.
// Optional feature macro: BEST_DONE_IRQ_EN adds a one-cycle done_irq pulse.
module knn_best_mem_ctrl
  import knn_best_pkg::*;
(
  input  logic                wb_clk_i,
  input  logic                rst_n,
  input  logic                wbs_debug,
  input  logic                start,
  knn_best_mem_ctrl_if.slave  bus,
  output logic                done
`ifdef BEST_DONE_IRQ_EN
  ,
  output logic                done_irq
`endif
);

  // Engine-side state
  beat_t              beat_cnt_q, beat_cnt_d;
  qaddr_t             q_addr_q,   q_addr_d;
  logic [SHIFT_W-1:0] shift_q,    shift_d;
  logic               done_q,     done_d;
  logic               run_q,      run_d;

  // Bus read-return state
  logic               rd_pend_q,  rd_pend_d;
  logic               rd_oor_q,   rd_oor_d;
  logic [RDATA_W-1:0] rdata0_q,   rdata0_d;

`ifdef BEST_DONE_IRQ_EN
  logic               done_dly_q, done_dly_d;
  logic               done_irq_q, done_irq_d;
`endif

  logic               res_ready;
  logic               accept;
  logic               last_beat;
  logic               row_we;
  logic               rd_req;
  logic               rd_hit;
  logic               ram_en;
  logic               ram_we;
  qaddr_t             ram_addr;
  best_row_t          ram_wdata;
  best_row_t          ram_rdata;
  logic [RDATA_W-1:0] rd_word;
  logic [RDATA_W-1:0] rdata_out;

  // The engine may push only once out of reset, outside debug and before the frame is complete.
  assign res_ready = run_q & ~wbs_debug & ~done_q;
  assign accept    = bus.res_valid & res_ready;
  assign last_beat = (beat_cnt_q == BEAT_W'(K - 1));
  assign row_we    = accept & last_beat & ~start;
  assign rd_req    = wbs_debug & ~bus.wbs_best_mem_csb0 & bus.wbs_best_mem_web0;
  assign rd_hit    = rd_req & addr_in_range(bus.wbs_best_mem_addr0);

  // Beat counting, packing, row addressing and frame completion.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    q_addr_d   = q_addr_q;
    shift_d    = shift_q;
    done_d     = done_q;
    run_d      = 1'b1;
    if (start) begin
      beat_cnt_d = '0;
      q_addr_d   = '0;
      shift_d    = '0;
      done_d     = 1'b0;
    end else if (accept) begin
      if (last_beat) begin
        beat_cnt_d = '0;
        shift_d    = '0;
        if (q_addr_q == QADDR_W'(NUM_QUERYS - 1)) begin
          q_addr_d = '0;
          done_d   = 1'b1;
        end else begin
          q_addr_d = q_addr_q + QADDR_W'(1);
        end
      end else begin
        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        for (int n = 0; n < K - 1; n++) begin
          if (beat_cnt_q == BEAT_W'(n)) begin
            shift_d[n*IDX_W +: IDX_W] = bus.res_idx;
          end else begin
            shift_d[n*IDX_W +: IDX_W] = shift_q[n*IDX_W +: IDX_W];
          end
        end
      end
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
  end

  // Single RAM port: the bus owns it in debug, the engine otherwise.
  always_comb begin
    ram_wdata = {bus.res_idx, shift_q};
    if (wbs_debug) begin
      ram_en   = rd_hit;
      ram_we   = 1'b0;
      ram_addr = bus.wbs_best_mem_addr0;
    end else begin
      ram_en   = row_we;
      ram_we   = row_we;
      ram_addr = q_addr_q;
    end
  end

  // Read return: fresh RAM data the cycle after a read, held value otherwise; out-of-range reads give zero.
  always_comb begin
    if (rd_oor_q) begin
      rd_word = '0;
    end else begin
      rd_word = RDATA_W'(ram_rdata);
    end
    if (rd_pend_q) begin
      rdata_out = rd_word;
    end else begin
      rdata_out = rdata0_q;
    end
    rdata0_d  = rdata_out;
    rd_pend_d = rd_req;
    if (rd_req) begin
      rd_oor_d = ~addr_in_range(bus.wbs_best_mem_addr0);
    end else begin
      rd_oor_d = rd_oor_q;
    end
  end

`ifdef BEST_DONE_IRQ_EN
  // One-cycle pulse following the rise of done, dropped when a new frame starts.
  always_comb begin
    done_dly_d = done_q;
    done_irq_d = done_q & ~done_dly_q & ~start;
  end
`endif

  // State registers with synchronous active-low reset.
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      q_addr_q   <= '0;
      shift_q    <= '0;
      done_q     <= 1'b0;
      run_q      <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_oor_q   <= 1'b0;
      rdata0_q   <= '0;
`ifdef BEST_DONE_IRQ_EN
      done_dly_q <= 1'b0;
      done_irq_q <= 1'b0;
`endif
    end else begin
      beat_cnt_q <= beat_cnt_d;
      q_addr_q   <= q_addr_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
      run_q      <= run_d;
      rd_pend_q  <= rd_pend_d;
      rd_oor_q   <= rd_oor_d;
      rdata0_q   <= rdata0_d;
`ifdef BEST_DONE_IRQ_EN
      done_dly_q <= done_dly_d;
      done_irq_q <= done_irq_d;
`endif
    end
  end

  best_row_ram u_ram (
    .clk   (wb_clk_i),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign bus.res_ready           = res_ready;
  assign bus.wbs_best_mem_rdata0 = rdata_out;
  assign done                    = done_q;
`ifdef BEST_DONE_IRQ_EN
  assign done_irq                = done_irq_q;
`endif

endmodule
